// File: rtl/sdram_pkg.sv
// Shared definitions for the multi-port SDRAM arbiter: SDRAM command codes,
// arbiter state encodings and the pin-bus bundle used by the output mux.
package sdram_pkg;

  // SDRAM commands as {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  // Arbiter states
  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_ATREF = 3'd2;
  localparam logic [2:0] ST_WR    = 3'd3;
  localparam logic [2:0] ST_RD    = 3'd4;

  // One engine's command/address bus as presented to the SDRAM pins
  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  bank;
    logic [12:0] addr;
  } sdram_bus_t;

  localparam sdram_bus_t BUS_NOP = '{cmd: CMD_NOP, bank: 2'd0, addr: 13'd0};

endpackage

// File: rtl/sdram_rr_arb.sv
// Rotating-priority request picker: the search starts at ptr and wraps, the
// first asserted request wins. With ptr held at zero this is plain fixed
// priority with channel 0 highest.
module sdram_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int PW     = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [PW-1:0]     idx,
  output logic              valid
);

  // Walk the channels starting at ptr and take the first requester
  always_comb begin
    int c;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!valid && req[c]) begin
        valid  = 1'b1;
        idx    = PW'(c);
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_mp_arbit.sv
// Multi-channel SDRAM arbiter: serialises init, auto-refresh and NUM_CH
// client burst requests onto one SDRAM command/data bus.
// Build option: SDRAM_ARB_FIXED_PRIO_EN selects fixed priority (channel 0
// highest); left undefined the channels are served round-robin.
module sdram_mp_arbit
  import sdram_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int AW     = 24,
  parameter int LW     = 10,
  parameter int DW     = 16,
  localparam int PW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 sdram_clk,
  input  logic                 sdram_rst,
  input  logic                 init_end,
  input  logic [3:0]           init_cmd,
  input  logic [1:0]           init_bank,
  input  logic [12:0]          init_addr,
  input  logic                 atref_req,
  input  logic                 atref_end,
  input  logic [3:0]           atref_cmd,
  input  logic [1:0]           atref_bank,
  input  logic [12:0]          atref_addr,
  input  logic                 wr_end,
  input  logic                 rd_end,
  input  logic [3:0]           wr_cmd,
  input  logic [1:0]           wr_bank,
  input  logic [12:0]          wr_addr,
  input  logic                 wr_dq_en,
  input  logic [DW-1:0]        wr_dq,
  input  logic [3:0]           rd_cmd,
  input  logic [1:0]           rd_bank,
  input  logic [12:0]          rd_addr,
  input  logic [NUM_CH-1:0]    ch_req,
  input  logic [NUM_CH-1:0]    ch_we,
  input  logic [NUM_CH*AW-1:0] ch_addr,
  input  logic [NUM_CH*LW-1:0] ch_len,
  output logic [NUM_CH-1:0]    ch_gnt,
  output logic [NUM_CH-1:0]    ch_done,
  output logic                 atref_en,
  output logic                 wr_en,
  output logic                 rd_en,
  output logic [AW-1:0]        eng_addr,
  output logic [LW-1:0]        eng_len,
  output logic [PW-1:0]        cur_ch,
  output logic                 sdram_cke,
  output logic                 sdram_cs_n,
  output logic                 sdram_ras_n,
  output logic                 sdram_cas_n,
  output logic                 sdram_we_n,
  output logic [1:0]           sdram_bank,
  output logic [12:0]          sdram_addr,
  output logic                 sdram_dq_oe,
  output logic [DW-1:0]        sdram_dq_out
);

  logic [2:0]        state_q, state_d;
  logic [NUM_CH-1:0] ch_gnt_q, ch_done_q;
  logic              atref_en_q, wr_en_q, rd_en_q;
  logic [AW-1:0]     eng_addr_q;
  logic [LW-1:0]     eng_len_q;
  logic [PW-1:0]     cur_ch_q;

  logic [NUM_CH-1:0] req_eff, arb_gnt, done_vec;
  logic [PW-1:0]     arb_ptr, arb_idx;
  logic              arb_valid;
  logic [AW-1:0]     sel_addr;
  logic [LW-1:0]     sel_len;
  logic              sel_we, sel_len_nz;
  logic              grant_fire, start_fire, burst_end;
  sdram_bus_t        pin_bus;

  // A channel whose grant is on the wire this cycle has not yet had the
  // chance to drop its request; hide it so it is not granted twice.
  assign req_eff = ch_req & ~ch_gnt_q;

  sdram_rr_arb #(
    .NUM_CH (NUM_CH),
    .PW     (PW)
  ) u_arb (
    .req   (req_eff),
    .ptr   (arb_ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign sel_addr   = ch_addr[int'(arb_idx)*AW +: AW];
  assign sel_len    = ch_len[int'(arb_idx)*LW +: LW];
  assign sel_we     = ch_we[arb_idx];
  assign sel_len_nz = |sel_len;

  // Refresh wins over channels in IDLE; a zero-length grant completes at once
  assign grant_fire = (state_q == ST_IDLE) && !atref_req && arb_valid;
  assign start_fire = grant_fire && sel_len_nz;
  assign burst_end  = ((state_q == ST_WR) && wr_end) || ((state_q == ST_RD) && rd_end);
  assign done_vec   = NUM_CH'(1) << cur_ch_q;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [PW-1:0] ptr_q, ptr_d;

  assign ptr_d = (arb_idx == PW'(NUM_CH - 1)) ? '0 : arb_idx + PW'(1);

  // Round-robin pointer: next search starts just past the last winner
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      ptr_q <= '0;
    end else if (grant_fire) begin
      ptr_q <= ptr_d;
    end
  end

  assign arb_ptr = ptr_q;
`endif

  // Next-state decision; burst completion goes straight to refresh if pending
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (init_end) state_d = ST_IDLE;
      ST_IDLE: begin
        if (atref_req)       state_d = ST_ATREF;
        else if (start_fire) state_d = sel_we ? ST_WR : ST_RD;
      end
      ST_ATREF: if (atref_end) state_d = ST_IDLE;
      ST_WR:    if (wr_end) state_d = atref_req ? ST_ATREF : ST_IDLE;
      ST_RD:    if (rd_end) state_d = atref_req ? ST_ATREF : ST_IDLE;
      default:  state_d = ST_INIT;
    endcase
  end

  // State, handshake pulses and the latched burst descriptor
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state_q    <= ST_INIT;
      ch_gnt_q   <= '0;
      ch_done_q  <= '0;
      atref_en_q <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      eng_addr_q <= '0;
      eng_len_q  <= '0;
      cur_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      ch_gnt_q   <= grant_fire ? arb_gnt : '0;
      if (burst_end)
        ch_done_q <= done_vec;
      else if (grant_fire && !sel_len_nz)
        ch_done_q <= arb_gnt;
      else
        ch_done_q <= '0;
      atref_en_q <= (state_d == ST_ATREF) && (state_q != ST_ATREF);
      wr_en_q    <= start_fire && sel_we;
      rd_en_q    <= start_fire && !sel_we;
      if (start_fire) begin
        eng_addr_q <= sel_addr;
        eng_len_q  <= sel_len;
        cur_ch_q   <= arb_idx;
      end
    end
  end

  // Pin mux follows the current owner so engine timing passes through unchanged
  always_comb begin
    pin_bus      = BUS_NOP;
    sdram_dq_oe  = 1'b0;
    sdram_dq_out = '0;
    case (state_q)
      ST_INIT:  pin_bus = '{cmd: init_cmd, bank: init_bank, addr: init_addr};
      ST_ATREF: pin_bus = '{cmd: atref_cmd, bank: atref_bank, addr: atref_addr};
      ST_WR: begin
        pin_bus      = '{cmd: wr_cmd, bank: wr_bank, addr: wr_addr};
        sdram_dq_oe  = wr_dq_en;
        sdram_dq_out = wr_dq;
      end
      ST_RD:    pin_bus = '{cmd: rd_cmd, bank: rd_bank, addr: rd_addr};
      default:  pin_bus = BUS_NOP;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pin_bus.cmd;
  assign sdram_bank = pin_bus.bank;
  assign sdram_addr = pin_bus.addr;
  assign sdram_cke  = 1'b1;

  assign ch_gnt   = ch_gnt_q;
  assign ch_done  = ch_done_q;
  assign atref_en = atref_en_q;
  assign wr_en    = wr_en_q;
  assign rd_en    = rd_en_q;
  assign eng_addr = eng_addr_q;
  assign eng_len  = eng_len_q;
  assign cur_ch   = cur_ch_q;

endmodule

// File: tb/tb_sdram_mp_arbit.sv
// Directed bench for sdram_mp_arbit: reset, init, round-robin order, refresh
// between bursts, zero-length grant, reset mid-burst. With
// SDRAM_ARB_FIXED_PRIO_EN defined the round-robin step is replaced by a
// fixed-priority step.
module tb_sdram_mp_arbit;

  localparam int NUM_CH = 4;
  localparam int AW = 24;
  localparam int LW = 10;
  localparam int DW = 16;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] MRS = 4'b0000;
  localparam logic [3:0] ARF = 4'b0001;
  localparam logic [3:0] WRC = 4'b0100;
  localparam logic [3:0] RDC = 4'b0101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, init_end, atref_req, atref_end, wr_end, rd_end, wr_dq_en;
  logic [3:0] init_cmd, atref_cmd, wr_cmd, rd_cmd;
  logic [1:0] init_bank, atref_bank, wr_bank, rd_bank;
  logic [12:0] init_addr, atref_addr, wr_addr, rd_addr;
  logic [DW-1:0] wr_dq;
  logic [NUM_CH-1:0] ch_req, ch_we;
  logic [NUM_CH*AW-1:0] ch_addr;
  logic [NUM_CH*LW-1:0] ch_len;
  logic [NUM_CH-1:0] ch_gnt, ch_done;
  logic atref_en, wr_en, rd_en;
  logic [AW-1:0] eng_addr;
  logic [LW-1:0] eng_len;
  logic [1:0] cur_ch;
  logic cke, cs_n, ras_n, cas_n, we_n, dq_oe;
  logic [1:0] bank;
  logic [12:0] addr;
  logic [DW-1:0] dq_out;
  logic [3:0] pin_cmd;

  assign pin_cmd = {cs_n, ras_n, cas_n, we_n};

  sdram_mp_arbit #(.NUM_CH(NUM_CH), .AW(AW), .LW(LW), .DW(DW)) dut (
    .sdram_clk(clk), .sdram_rst(rst), .init_end(init_end),
    .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .atref_req(atref_req), .atref_end(atref_end),
    .atref_cmd(atref_cmd), .atref_bank(atref_bank), .atref_addr(atref_addr),
    .wr_end(wr_end), .rd_end(rd_end),
    .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_dq_en(wr_dq_en), .wr_dq(wr_dq),
    .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_len(ch_len),
    .ch_gnt(ch_gnt), .ch_done(ch_done),
    .atref_en(atref_en), .wr_en(wr_en), .rd_en(rd_en),
    .eng_addr(eng_addr), .eng_len(eng_len), .cur_ch(cur_ch),
    .sdram_cke(cke), .sdram_cs_n(cs_n), .sdram_ras_n(ras_n),
    .sdram_cas_n(cas_n), .sdram_we_n(we_n),
    .sdram_bank(bank), .sdram_addr(addr),
    .sdram_dq_oe(dq_oe), .sdram_dq_out(dq_out)
  );

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] addr_tab [NUM_CH];
  logic [LW-1:0] len_tab  [NUM_CH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack_desc();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_addr[i*AW +: AW] = addr_tab[i];
      ch_len[i*LW +: LW]  = len_tab[i];
    end
  endtask

  // Wait for the grant of one non-empty burst, act as the engine, finish it
  task automatic serve(input int ch, input bit we, input bit rereq, input bit atref_mid);
    int n;
    logic [NUM_CH-1:0] oh;
    oh = NUM_CH'(1) << ch;
    n = 0;
    do begin
      tick();
      n++;
    end while (ch_gnt == '0 && n < 20);
    chk("gnt_timeout", 32'(ch_gnt != '0), 32'd1);
    chk("gnt", 32'(ch_gnt), 32'(oh));
    chk("wr_en", 32'(wr_en), 32'(we));
    chk("rd_en", 32'(rd_en), 32'(!we));
    chk("cur_ch", 32'(cur_ch), 32'(ch));
    chk("eng_addr", 32'(eng_addr), 32'(addr_tab[ch]));
    chk("eng_len", 32'(eng_len), 32'(len_tab[ch]));
    chk("cmd_burst", 32'(pin_cmd), 32'(we ? WRC : RDC));
    ch_req[ch] = 1'b0;
    if (atref_mid) atref_req = 1'b1;
    tick();
    chk("gnt_pulse", 32'(ch_gnt), 32'd0);
    if (we) begin
      wr_dq_en = 1'b1;
      wr_dq = 16'hA5A0 | 16'(ch);
      #1;
      chk("dq_oe", 32'(dq_oe), 32'd1);
      chk("dq_out", 32'(dq_out), 32'(16'hA5A0 | 16'(ch)));
      wr_dq_en = 1'b0;
    end
    tick();
    chk("done_early", 32'(ch_done), 32'd0);
    if (we) wr_end = 1'b1; else rd_end = 1'b1;
    tick();
    wr_end = 1'b0;
    rd_end = 1'b0;
    chk("done", 32'(ch_done), 32'(oh));
    if (atref_mid) begin
      chk("atref_en", 32'(atref_en), 32'd1);
      chk("cmd_atref", 32'(pin_cmd), 32'(ARF));
      atref_req = 1'b0;
      tick();
      chk("atref_hold_gnt", 32'(ch_gnt), 32'd0);
      atref_end = 1'b1;
      tick();
      atref_end = 1'b0;
      chk("cmd_after_atref", 32'(pin_cmd), 32'(NOP));
    end else begin
      chk("atref_idle", 32'(atref_en), 32'd0);
      chk("cmd_idle", 32'(pin_cmd), 32'(NOP));
    end
    if (rereq) ch_req[ch] = 1'b1;
    $display("txn ch=%0d we=%0d addr=%06h len=%0d atref_after=%0d", ch, we, addr_tab[ch], len_tab[ch], atref_mid);
  endtask

  initial begin
    int n;
    addr_tab[0] = 24'h0C1000; addr_tab[1] = 24'h1A2040;
    addr_tab[2] = 24'h2B3080; addr_tab[3] = 24'h3C40C0;
    for (int i = 0; i < NUM_CH; i++) len_tab[i] = 10'd8;
    pack_desc();
    rst = 1'b1; init_end = 1'b0; atref_req = 1'b0; atref_end = 1'b0;
    wr_end = 1'b0; rd_end = 1'b0; wr_dq_en = 1'b0; wr_dq = '0;
    init_cmd = NOP; init_bank = 2'd0; init_addr = 13'd0;
    atref_cmd = ARF; atref_bank = 2'd1; atref_addr = 13'h0400;
    wr_cmd = WRC; wr_bank = 2'd2; wr_addr = 13'h0011;
    rd_cmd = RDC; rd_bank = 2'd3; rd_addr = 13'h0022;
    ch_req = '0; ch_we = 4'b1111;

    // Reset values
    tick(); tick();
    chk("rst_gnt", 32'(ch_gnt), 32'd0);
    chk("rst_done", 32'(ch_done), 32'd0);
    chk("rst_en", 32'({atref_en, wr_en, rd_en}), 32'd0);
    chk("rst_eng", 32'({eng_addr, cur_ch}), 32'd0);
    chk("rst_cmd", 32'(pin_cmd), 32'(NOP));
    chk("rst_cke_oe", 32'({cke, dq_oe}), 32'b10);
    rst = 1'b0;

    // INIT passes the init engine bus, init_end moves to IDLE (NOP)
    init_cmd = MRS;
    tick();
    chk("init_cmd", 32'(pin_cmd), 32'(MRS));
    init_end = 1'b1;
    tick();
    chk("idle_cmd", 32'(pin_cmd), 32'(NOP));
    chk("idle_gnt", 32'(ch_gnt), 32'd0);
    init_cmd = NOP;

`ifndef SDRAM_ARB_FIXED_PRIO_EN
    // Round robin over four writers, refresh slipped in after channel 2
    ch_req = 4'b1111;
    serve(0, 1'b1, 1'b1, 1'b0);
    serve(1, 1'b1, 1'b1, 1'b0);
    serve(2, 1'b1, 1'b1, 1'b1);
    serve(3, 1'b1, 1'b1, 1'b0);
    serve(0, 1'b1, 1'b0, 1'b0);
    ch_req = '0;
`else
    // Fixed priority: channel 1 keeps beating channel 3
    ch_req = 4'b1010;
    serve(1, 1'b1, 1'b1, 1'b0);
    serve(1, 1'b1, 1'b0, 1'b0);
    serve(3, 1'b1, 1'b0, 1'b0);
    ch_req = '0;
`endif
    tick();

    // Zero-length request: grant and done together, no engine start
    len_tab[1] = 10'd0;
    pack_desc();
    ch_req[1] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (ch_gnt == '0 && n < 20);
    chk("z_gnt", 32'(ch_gnt), 32'b0010);
    chk("z_done", 32'(ch_done), 32'b0010);
    chk("z_en", 32'({wr_en, rd_en}), 32'd0);
    chk("z_cmd", 32'(pin_cmd), 32'(NOP));
    ch_req[1] = 1'b0;
    tick();
    chk("z_after", 32'({ch_gnt, ch_done}), 32'd0);
    $display("txn ch=1 len=0 zero-length grant");
    len_tab[1] = 10'd8;
    pack_desc();

    // Reset in the middle of a read burst on channel 2
    ch_we[2] = 1'b0;
    ch_req[2] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (ch_gnt == '0 && n < 20);
    chk("r_gnt", 32'(ch_gnt), 32'b0100);
    chk("r_rd_en", 32'(rd_en), 32'd1);
    ch_req[2] = 1'b0;
    tick();
    chk("r_cmd", 32'(pin_cmd), 32'(RDC));
    init_end = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_gnt_done", 32'({ch_gnt, ch_done}), 32'd0);
    chk("mr_en", 32'({atref_en, wr_en, rd_en}), 32'd0);
    chk("mr_eng_addr", 32'(eng_addr), 32'd0);
    chk("mr_eng_len_ch", 32'({eng_len, cur_ch}), 32'd0);
    chk("mr_cmd", 32'(pin_cmd), 32'(NOP));
    chk("mr_oe", 32'(dq_oe), 32'd0);
    $display("txn reset during read ch=2");

    // Still in INIT: requests wait until init_end
    ch_req[0] = 1'b1;
    ch_we[0] = 1'b0;
    tick(); tick(); tick();
    chk("init_wait", 32'(ch_gnt), 32'd0);
    init_end = 1'b1;
    serve(0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
